// File: rtl/moving_obstacle_move_controller_if.sv
// rtl/moving_obstacle_move_controller_if.sv - frame/control and position signals of the obstacle motion controller
interface moving_obstacle_move_controller_if;
  logic               startOfFrame;
  logic               launch;
  logic               collision;
  logic signed [10:0] spawnX;
  logic signed [10:0] topLeftX;
  logic signed [10:0] topLeftY;
  logic               visible;
  logic               hitFlag;
  logic               escaped;

  // Frame/game logic side: drives requests, observes the object placement.
  modport master (
    output startOfFrame, launch, collision, spawnX,
    input  topLeftX, topLeftY, visible, hitFlag, escaped
  );

  // Motion controller side.
  modport slave (
    input  startOfFrame, launch, collision, spawnX,
    output topLeftX, topLeftY, visible, hitFlag, escaped
  );
endinterface

// File: rtl/moving_obstacle_move_controller.sv
// rtl/moving_obstacle_move_controller.sv - per-frame bounce/fall motion, hit flash, respawn and escape sequencing
module moving_obstacle_move_controller #(
  parameter int INITIAL_X       = 280,
  parameter int INITIAL_Y       = -64,
  parameter int X_SPEED         = 64,
  parameter int Y_SPEED         = 128,
  parameter int OBJECT_WIDTH_X  = 64,
  parameter int OBJECT_HEIGHT_Y = 64,
  parameter int SCREEN_WIDTH    = 640,
  parameter int SCREEN_HEIGHT   = 480,
  parameter int HIT_FRAMES      = 16,
  parameter int RESPAWN_FRAMES  = 32
) (
  input  logic clk,
  input  logic reset,
  moving_obstacle_move_controller_if.slave bus
);

  // Positions are pixels scaled by 64 (6 fractional bits).
  localparam int MAX_LEFT = SCREEN_WIDTH - OBJECT_WIDTH_X;
  localparam logic signed [31:0] FP_INIT_X   = INITIAL_X * 64;
  localparam logic signed [31:0] FP_INIT_Y   = INITIAL_Y * 64;
  localparam logic signed [31:0] FP_MAX_LEFT = MAX_LEFT * 64;
  localparam int CNT_MAX = (HIT_FRAMES > RESPAWN_FRAMES) ? HIT_FRAMES : RESPAWN_FRAMES;
  // One spare bit keeps frameCnt[1] addressable even for tiny frame counts.
  localparam int CNT_W = $clog2(CNT_MAX) + 1;
  localparam logic [CNT_W-1:0] HIT_LOAD  = CNT_W'(HIT_FRAMES - 1);
  localparam logic [CNT_W-1:0] RESP_LOAD = CNT_W'(RESPAWN_FRAMES - 1);

  localparam bit PARAMS_OK = (HIT_FRAMES >= 2) && (RESPAWN_FRAMES >= 1) && (Y_SPEED > 0) &&
                             (OBJECT_WIDTH_X > 0) && (OBJECT_HEIGHT_Y > 0) &&
                             (OBJECT_WIDTH_X <= SCREEN_WIDTH);
  if (!PARAMS_OK) begin : g_bad_params
    $error("moving_obstacle_move_controller: inconsistent parameters");
  end

  typedef enum logic [1:0] {S_IDLE, S_MOVING, S_HIT, S_RESPAWN} state_t;

  state_t             state_q, state_n;
  logic signed [31:0] x_q, x_n, y_q, y_n, spd_q, spd_n;
  logic signed [31:0] new_x, new_y, new_left, new_top;
  logic [CNT_W-1:0]   cnt_q, cnt_n;
  logic               coll_q;
  logic               esc_n, vis_n, hit_n;
  logic signed [10:0] tlx_q, tly_q;
  logic               vis_q, hit_q, esc_q;

  // Spawn X limited to the on-screen range, returned in fixed point.
  function automatic logic signed [31:0] clamp_fp(input logic signed [10:0] v);
    logic signed [31:0] p;
    p = {{21{v[10]}}, v};
    if (p < 0)
      p = 0;
    else if (p > MAX_LEFT)
      p = MAX_LEFT;
    return p <<< 6;
  endfunction

  // Collision is remembered for the rest of the frame and judged at the next frame start.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      coll_q <= 1'b0;
    else if (bus.startOfFrame)
      coll_q <= 1'b0;
    else if (state_q == S_MOVING && bus.collision)
      coll_q <= 1'b1;
  end

  // Next state, next position/speed/counter and the output values that go with them.
  always_comb begin
    state_n  = state_q;
    x_n      = x_q;
    y_n      = y_q;
    spd_n    = spd_q;
    cnt_n    = cnt_q;
    esc_n    = 1'b0;
    new_x    = x_q + spd_q;
    new_y    = y_q + Y_SPEED;
    new_left = new_x >>> 6;
    new_top  = new_y >>> 6;
    case (state_q)
      S_IDLE: begin
        if (bus.launch) begin
          state_n = S_MOVING;
          x_n     = clamp_fp(bus.spawnX);
          y_n     = FP_INIT_Y;
        end
      end
      S_MOVING: begin
        if (bus.startOfFrame) begin
          if (coll_q) begin
            // A hit freezes the object where it is, even at a wall or the bottom.
            state_n = S_HIT;
            cnt_n   = HIT_LOAD;
          end else begin
            x_n = new_x;
            y_n = new_y;
            if (new_left < 0) begin
              x_n   = '0;
              spd_n = X_SPEED;
            end else if (new_left + OBJECT_WIDTH_X > SCREEN_WIDTH) begin
              x_n   = FP_MAX_LEFT;
              spd_n = -X_SPEED;
            end
            if (new_top >= SCREEN_HEIGHT) begin
              esc_n   = 1'b1;
              state_n = S_RESPAWN;
              cnt_n   = RESP_LOAD;
              x_n     = clamp_fp(bus.spawnX);
              y_n     = FP_INIT_Y;
            end
          end
        end
      end
      S_HIT: begin
        if (bus.startOfFrame) begin
          if (cnt_q == '0) begin
            state_n = S_RESPAWN;
            cnt_n   = RESP_LOAD;
            x_n     = clamp_fp(bus.spawnX);
            y_n     = FP_INIT_Y;
          end else begin
            cnt_n = cnt_q - CNT_W'(1);
          end
        end
      end
      S_RESPAWN: begin
        if (bus.startOfFrame) begin
          if (cnt_q == '0)
            state_n = S_MOVING;
          else
            cnt_n = cnt_q - CNT_W'(1);
        end
      end
      default: state_n = S_IDLE;
    endcase
    hit_n = (state_n == S_HIT);
    case (state_n)
      S_MOVING: vis_n = 1'b1;
      S_HIT:    vis_n = cnt_n[1];
      default:  vis_n = 1'b0;
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      state_q <= S_IDLE;
    else
      state_q <= state_n;
  end

  // Motion state and registered outputs, updated together so outputs track state with one cycle latency.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      x_q   <= FP_INIT_X;
      y_q   <= FP_INIT_Y;
      spd_q <= X_SPEED;
      cnt_q <= '0;
      tlx_q <= FP_INIT_X[16:6];
      tly_q <= FP_INIT_Y[16:6];
      vis_q <= 1'b0;
      hit_q <= 1'b0;
      esc_q <= 1'b0;
    end else begin
      x_q   <= x_n;
      y_q   <= y_n;
      spd_q <= spd_n;
      cnt_q <= cnt_n;
      tlx_q <= x_n[16:6];
      tly_q <= y_n[16:6];
      vis_q <= vis_n;
      hit_q <= hit_n;
      esc_q <= esc_n;
    end
  end

  assign bus.topLeftX = tlx_q;
  assign bus.topLeftY = tly_q;
  assign bus.visible  = vis_q;
  assign bus.hitFlag  = hit_q;
  assign bus.escaped  = esc_q;

endmodule

// File: tb/tb_moving_obstacle_move_controller.sv
// tb/tb_moving_obstacle_move_controller.sv - directed self-checking bench for the obstacle motion controller
module tb_moving_obstacle_move_controller;
  logic clk;
  logic reset;
  int   n_checks;
  int   n_fail;
  logic [15:0] flash_exp;
  int   esc_seen;

  moving_obstacle_move_controller_if bus ();

  moving_obstacle_move_controller dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog expired before end of test");
    $fatal(1, "watchdog");
  end

  task automatic sof_frame();
    @(negedge clk);
    bus.startOfFrame = 1'b1;
    @(negedge clk);
    bus.startOfFrame = 1'b0;
  endtask

  task automatic do_launch(input logic signed [10:0] sx);
    @(negedge clk);
    bus.spawnX = sx;
    bus.launch = 1'b1;
    @(negedge clk);
    bus.launch = 1'b0;
  endtask

  task automatic do_collide();
    @(negedge clk);
    bus.collision = 1'b1;
    @(negedge clk);
    bus.collision = 1'b0;
  endtask

  task automatic apply_reset();
    @(negedge clk);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_reset();
    apply_reset();
    n_checks++; if (bus.topLeftX !== 11'sd280) begin n_fail++; $display("FAIL reset_x actual=%0d required=280", bus.topLeftX); end
    n_checks++; if (bus.topLeftY !== -11'sd64) begin n_fail++; $display("FAIL reset_y actual=%0d required=-64", bus.topLeftY); end
    n_checks++; if ({bus.visible, bus.hitFlag, bus.escaped} !== 3'b000) begin n_fail++; $display("FAIL reset_flags actual=%b required=000", {bus.visible, bus.hitFlag, bus.escaped}); end
    // No launch: frame starts leave the object parked and hidden.
    sof_frame();
    sof_frame();
    n_checks++; if (bus.visible !== 1'b0 || bus.topLeftY !== -11'sd64) begin n_fail++; $display("FAIL idle_no_motion actual=vis%b y%0d required=vis0 y-64", bus.visible, bus.topLeftY); end
  endtask

  task automatic test_launch_motion();
    apply_reset();
    do_launch(11'sd100);
    n_checks++; if (bus.topLeftX !== 11'sd100 || bus.topLeftY !== -11'sd64 || bus.visible !== 1'b1) begin n_fail++; $display("FAIL launch_pos actual=x%0d y%0d vis%b required=x100 y-64 vis1", bus.topLeftX, bus.topLeftY, bus.visible); end
    for (int i = 1; i <= 4; i++) begin
      sof_frame();
      n_checks++; if (bus.visible !== 1'b1) begin n_fail++; $display("FAIL moving_visible frame=%0d actual=%b required=1", i, bus.visible); end
      // Launch while moving must not respawn the object.
      if (i == 2) do_launch(11'sd400);
    end
    n_checks++; if (bus.topLeftX !== 11'sd104) begin n_fail++; $display("FAIL move4_x actual=%0d required=104", bus.topLeftX); end
    n_checks++; if (bus.topLeftY !== -11'sd56) begin n_fail++; $display("FAIL move4_y actual=%0d required=-56", bus.topLeftY); end
  endtask

  task automatic test_wall_clamp();
    apply_reset();
    do_launch(11'sd700);
    n_checks++; if (bus.topLeftX !== 11'sd576) begin n_fail++; $display("FAIL spawn_clamp_x actual=%0d required=576", bus.topLeftX); end
    sof_frame();
    n_checks++; if (bus.topLeftX !== 11'sd576 || bus.topLeftY !== -11'sd62) begin n_fail++; $display("FAIL wall_pin actual=x%0d y%0d required=x576 y-62", bus.topLeftX, bus.topLeftY); end
    sof_frame();
    n_checks++; if (bus.topLeftX !== 11'sd575 || bus.topLeftY !== -11'sd60) begin n_fail++; $display("FAIL wall_bounce actual=x%0d y%0d required=x575 y-60", bus.topLeftX, bus.topLeftY); end
    // Negative spawn clamps to the left edge.
    apply_reset();
    do_launch(-11'sd37);
    n_checks++; if (bus.topLeftX !== 11'sd0) begin n_fail++; $display("FAIL spawn_clamp_neg actual=%0d required=0", bus.topLeftX); end
  endtask

  task automatic test_launch_with_sof();
    apply_reset();
    @(negedge clk);
    bus.spawnX = 11'sd50;
    bus.launch = 1'b1;
    bus.startOfFrame = 1'b1;
    @(negedge clk);
    bus.launch = 1'b0;
    bus.startOfFrame = 1'b0;
    n_checks++; if (bus.topLeftX !== 11'sd50 || bus.topLeftY !== -11'sd64 || bus.visible !== 1'b1) begin n_fail++; $display("FAIL launch_sof actual=x%0d y%0d vis%b required=x50 y-64 vis1", bus.topLeftX, bus.topLeftY, bus.visible); end
  endtask

  task automatic test_collision();
    flash_exp = 16'b0011_0011_0011_0011; // bit k = visible in HIT frame k
    apply_reset();
    do_launch(11'sd200);
    sof_frame();
    sof_frame();
    do_collide();
    bus.spawnX = -11'sd5;
    for (int k = 0; k < 16; k++) begin
      sof_frame();
      n_checks++; if (bus.hitFlag !== 1'b1) begin n_fail++; $display("FAIL hit_flag frame=%0d actual=%b required=1", k, bus.hitFlag); end
      n_checks++; if (bus.visible !== flash_exp[k]) begin n_fail++; $display("FAIL hit_flash frame=%0d actual=%b required=%b", k, bus.visible, flash_exp[k]); end
      n_checks++; if (bus.topLeftX !== 11'sd202 || bus.topLeftY !== -11'sd60) begin n_fail++; $display("FAIL hit_frozen frame=%0d actual=x%0d y%0d required=x202 y-60", k, bus.topLeftX, bus.topLeftY); end
      if (k == 5) do_collide();
    end
    sof_frame();
    n_checks++; if (bus.hitFlag !== 1'b0 || bus.visible !== 1'b0) begin n_fail++; $display("FAIL respawn_entry actual=hit%b vis%b required=hit0 vis0", bus.hitFlag, bus.visible); end
    n_checks++; if (bus.topLeftX !== 11'sd0 || bus.topLeftY !== -11'sd64) begin n_fail++; $display("FAIL respawn_pos actual=x%0d y%0d required=x0 y-64", bus.topLeftX, bus.topLeftY); end
    for (int f = 1; f <= 31; f++) begin
      sof_frame();
      n_checks++; if (bus.visible !== 1'b0) begin n_fail++; $display("FAIL respawn_hidden frame=%0d actual=%b required=0", f, bus.visible); end
    end
    sof_frame();
    n_checks++; if (bus.visible !== 1'b1 || bus.topLeftY !== -11'sd64) begin n_fail++; $display("FAIL respawn_exit actual=vis%b y%0d required=vis1 y-64", bus.visible, bus.topLeftY); end
    sof_frame();
    n_checks++; if (bus.topLeftX !== 11'sd1 || bus.topLeftY !== -11'sd62) begin n_fail++; $display("FAIL after_respawn_move actual=x%0d y%0d required=x1 y-62", bus.topLeftX, bus.topLeftY); end
  endtask

  task automatic test_escape();
    apply_reset();
    do_launch(11'sd300);
    esc_seen = 0;
    for (int f = 1; f <= 271; f++) begin
      sof_frame();
      if (bus.escaped === 1'b1) esc_seen++;
    end
    n_checks++; if (esc_seen != 0) begin n_fail++; $display("FAIL early_escape actual=%0d required=0", esc_seen); end
    n_checks++; if (bus.topLeftX !== 11'sd571 || bus.topLeftY !== 11'sd478) begin n_fail++; $display("FAIL pre_escape_pos actual=x%0d y%0d required=x571 y478", bus.topLeftX, bus.topLeftY); end
    bus.spawnX = 11'sd1000;
    sof_frame();
    n_checks++; if (bus.escaped !== 1'b1) begin n_fail++; $display("FAIL escaped_pulse actual=%b required=1", bus.escaped); end
    n_checks++; if (bus.visible !== 1'b0 || bus.topLeftX !== 11'sd576 || bus.topLeftY !== -11'sd64) begin n_fail++; $display("FAIL escape_respawn actual=vis%b x%0d y%0d required=vis0 x576 y-64", bus.visible, bus.topLeftX, bus.topLeftY); end
    @(negedge clk);
    n_checks++; if (bus.escaped !== 1'b0) begin n_fail++; $display("FAIL escaped_width actual=%b required=0", bus.escaped); end
    for (int f = 1; f <= 31; f++) begin
      sof_frame();
      n_checks++; if (bus.visible !== 1'b0 || bus.escaped !== 1'b0) begin n_fail++; $display("FAIL escape_hidden frame=%0d actual=vis%b esc%b required=vis0 esc0", f, bus.visible, bus.escaped); end
    end
    sof_frame();
    n_checks++; if (bus.visible !== 1'b1 || bus.topLeftY !== -11'sd64) begin n_fail++; $display("FAIL escape_remove actual=vis%b y%0d required=vis1 y-64", bus.visible, bus.topLeftY); end
  endtask

  task automatic test_collision_beats_escape();
    apply_reset();
    do_launch(11'sd300);
    for (int f = 1; f <= 271; f++) sof_frame();
    do_collide();
    sof_frame();
    n_checks++; if (bus.hitFlag !== 1'b1 || bus.escaped !== 1'b0) begin n_fail++; $display("FAIL coll_vs_exit actual=hit%b esc%b required=hit1 esc0", bus.hitFlag, bus.escaped); end
    n_checks++; if (bus.topLeftY !== 11'sd478) begin n_fail++; $display("FAIL coll_vs_exit_y actual=%0d required=478", bus.topLeftY); end
    @(negedge clk);
    n_checks++; if (bus.escaped !== 1'b0) begin n_fail++; $display("FAIL coll_vs_exit_late actual=%b required=0", bus.escaped); end
  endtask

  task automatic test_reset_mid_hit();
    apply_reset();
    do_launch(11'sd120);
    sof_frame();
    do_collide();
    sof_frame();
    n_checks++; if (bus.hitFlag !== 1'b1) begin n_fail++; $display("FAIL enter_hit actual=%b required=1", bus.hitFlag); end
    @(negedge clk);
    #2 reset = 1'b1;
    #1;
    n_checks++; if (bus.topLeftX !== 11'sd280 || bus.topLeftY !== -11'sd64) begin n_fail++; $display("FAIL async_reset_pos actual=x%0d y%0d required=x280 y-64", bus.topLeftX, bus.topLeftY); end
    n_checks++; if (bus.visible !== 1'b0 || bus.hitFlag !== 1'b0) begin n_fail++; $display("FAIL async_reset_flags actual=vis%b hit%b required=vis0 hit0", bus.visible, bus.hitFlag); end
    @(negedge clk);
    reset = 1'b0;
    sof_frame();
    n_checks++; if (bus.visible !== 1'b0 || bus.hitFlag !== 1'b0 || bus.topLeftY !== -11'sd64) begin n_fail++; $display("FAIL post_reset_idle actual=vis%b hit%b y%0d required=vis0 hit0 y-64", bus.visible, bus.hitFlag, bus.topLeftY); end
  endtask

  initial begin
    n_checks = 0;
    n_fail = 0;
    reset = 1'b1;
    bus.startOfFrame = 1'b0;
    bus.launch = 1'b0;
    bus.collision = 1'b0;
    bus.spawnX = '0;
    test_reset();
    test_launch_motion();
    test_wall_clamp();
    test_launch_with_sof();
    test_collision();
    test_escape();
    test_collision_beats_escape();
    test_reset_mid_hit();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
